// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg
//   Definitions shared by the instruction sequencer, its interface and its
//   program memory: instruction field positions, the NOP and HALT opcodes,
//   the sequencer state type and small word helpers.
package instr_sequencer_pkg;

  localparam int WORD_W   = 12;
  localparam int OPC_MSB  = 11;
  localparam int OPC_LSB  = 8;
  localparam int DATA_MSB = 7;

  // NOP decodes to "no CPU register enabled"; HALT ends a run and is
  // never forwarded to the CPU.
  localparam logic [OPC_MSB-OPC_LSB:0] NOP_OPCODE  = 4'hF;
  localparam logic [OPC_MSB-OPC_LSB:0] HALT_OPCODE = 4'hE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  function automatic logic [WORD_W-1:0] nop_word();
    return {NOP_OPCODE, {(DATA_MSB + 1){1'b0}}};
  endfunction

  function automatic logic is_halt(input logic [WORD_W-1:0] word);
    return word[OPC_MSB:OPC_LSB] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if
//   Program-load, run-control and CPU-facing signals of the sequencer.
//   master : the controller/testbench side (drives WrEn..Stop, sees outputs)
//   slave  : the sequencer side
//   Control inputs : WrEn, WrAddr, WrData, LastAddr, Start, Pause, Stop
//   Outputs        : Instr, InstrValid, Pc, Busy, Done
interface instr_sequencer_if #(
  parameter int AW = 4
);
  logic          WrEn;
  logic [AW-1:0] WrAddr;
  logic [11:0]   WrData;
  logic [AW-1:0] LastAddr;
  logic          Start;
  logic          Pause;
  logic          Stop;
  logic [11:0]   Instr;
  logic          InstrValid;
  logic [AW-1:0] Pc;
  logic          Busy;
  logic          Done;

  modport master (
    output WrEn, WrAddr, WrData, LastAddr, Start, Pause, Stop,
    input  Instr, InstrValid, Pc, Busy, Done
  );

  modport slave (
    input  WrEn, WrAddr, WrData, LastAddr, Start, Pause, Stop,
    output Instr, InstrValid, Pc, Busy, Done
  );
endinterface

// File: rtl/instr_sequencer_prog_mem.sv
// prog_mem
//   DEPTH x 12-bit program store. Synchronous write, asynchronous read; the
//   sequencer registers the read word, so the output path stays registered.
//   Contents are deliberately not reset.
//   clk_i      : clock, rising edge
//   wr_en_i    : write strobe (already gated by the sequencer state)
//   wr_addr_i  : write address
//   wr_data_i  : write word
//   rd_addr_i  : read address
//   rd_data_o  : word at rd_addr_i (combinational)
module prog_mem
  import instr_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [WORD_W-1:0] rd_data_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Steps through a small program and presents one 12-bit word per clock to
//   the CPU. Idle cycles carry a NOP word so CPU registers hold.
//   Clk   : clock, rising edge
//   Reset : synchronous, active-high
//   bus   : instr_sequencer_if.slave (program write port, Start/Pause/Stop,
//           Instr/InstrValid/Pc/Busy/Done)
//   Build option: define SEQ_LOOP_EN to wrap from the last address back to
//   address 0 without a bubble instead of finishing at the last address.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  instr_sequencer_if.slave bus
);

`ifdef SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  seq_state_e        state_q;
  logic [AW-1:0]     pc_q;
  logic [AW-1:0]     end_q;
  logic [WORD_W-1:0] instr_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  // Set when the most recently issued word came from address End.
  logic              at_end_q;

  logic              wr_en;
  logic [AW-1:0]     rd_addr;
  logic [WORD_W-1:0] rd_data;

  function automatic logic [AW-1:0] inc_addr(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  // Writes are locked out while a run is in progress. Outside RUN the only
  // fetch ever needed is address 0 (for Start); in loop mode the word after
  // End is also address 0.
  always_comb begin
    wr_en   = bus.WrEn && (state_q != RUN);
    rd_addr = pc_q;
    if (state_q != RUN) begin
      rd_addr = '0;
    end else if (LOOP_EN && at_end_q) begin
      rd_addr = '0;
    end
  end

  prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_mem (
    .clk_i     (Clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (bus.WrAddr),
    .wr_data_i (bus.WrData),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      end_q    <= '0;
      instr_q  <= nop_word();
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      at_end_q <= 1'b0;
    end else if (bus.Stop) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      instr_q  <= nop_word();
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      at_end_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.Start) begin
            end_q <= bus.LastAddr;
            if (is_halt(rd_data)) begin
              state_q <= DONE;
              pc_q    <= '0;
              instr_q <= nop_word();
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q  <= RUN;
              pc_q     <= inc_addr('0);
              instr_q  <= rd_data;
              valid_q  <= 1'b1;
              busy_q   <= 1'b1;
              done_q   <= 1'b0;
              at_end_q <= (bus.LastAddr == '0);
            end
          end
        end

        RUN: begin
          if (bus.Pause) begin
            // Pc and the End marker hold, so resuming neither skips nor
            // repeats a word.
            instr_q <= nop_word();
            valid_q <= 1'b0;
          end else if (!LOOP_EN && at_end_q) begin
            // Pc already points at End+1 and is left there.
            state_q <= DONE;
            instr_q <= nop_word();
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (is_halt(rd_data)) begin
            state_q <= DONE;
            pc_q    <= rd_addr;
            instr_q <= nop_word();
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            pc_q     <= inc_addr(rd_addr);
            instr_q  <= rd_data;
            valid_q  <= 1'b1;
            at_end_q <= (rd_addr == end_q);
          end
        end

        default: begin
          state_q <= IDLE;
          pc_q    <= '0;
          instr_q <= nop_word();
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Instr      = instr_q;
  assign bus.InstrValid = valid_q;
  assign bus.Pc         = pc_q;
  assign bus.Busy       = busy_q;
  assign bus.Done       = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer
//   Table-driven checks of the program scenarios, hand-written multi-cycle
//   corner cases, and randomized runs compared against an issue-list model.
//   Build option SEQ_LOOP_EN selects the wrap-around scenario instead of the
//   end-of-program scenarios.
module tb_instr_sequencer;

  logic clk;
  logic rst;

  instr_sequencer_if #(.AW(4)) bus ();

  instr_sequencer #(
    .DEPTH (16),
    .AW    (4)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  logic [11:0] model_mem [16];

  typedef struct {
    logic        wr;
    logic [3:0]  wa;
    logic [11:0] wd;
    logic [3:0]  last;
    logic        st;
    logic        pa;
    logic        sp;
    logic [11:0] ei;
    logic        ev;
    logic [3:0]  ep;
    logic        eb;
    logic        ed;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [3:0] wa, input logic [11:0] wd,
                              input logic [3:0] last, input logic st, input logic pa,
                              input logic sp, input logic [11:0] ei, input logic ev,
                              input logic [3:0] ep, input logic eb, input logic ed);
    vec_t v;
    v.wr = wr; v.wa = wa; v.wd = wd; v.last = last; v.st = st; v.pa = pa; v.sp = sp;
    v.ei = ei; v.ev = ev; v.ep = ep; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  task automatic drive(input logic wr, input logic [3:0] wa, input logic [11:0] wd,
                       input logic [3:0] last, input logic st, input logic pa, input logic sp);
    bus.WrEn     = wr;
    bus.WrAddr   = wa;
    bus.WrData   = wd;
    bus.LastAddr = last;
    bus.Start    = st;
    bus.Pause    = pa;
    bus.Stop     = sp;
    // Mirror only writes the design is supposed to honour.
    if (wr && !bus.Busy) model_mem[wa] = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [11:0] ei, input logic ev,
                       input logic [3:0] ep, input logic eb, input logic ed);
    total++;
    if (bus.Instr !== ei || bus.InstrValid !== ev || bus.Pc !== ep ||
        bus.Busy !== eb || bus.Done !== ed) begin
      bad++;
      $display("FAIL %s: got instr=%h valid=%b pc=%0d busy=%b done=%b, want instr=%h valid=%b pc=%0d busy=%b done=%b",
               name, bus.Instr, bus.InstrValid, bus.Pc, bus.Busy, bus.Done, ei, ev, ep, eb, ed);
    end else begin
      $display("ok   %s: instr=%h valid=%b pc=%0d busy=%b done=%b",
               name, bus.Instr, bus.InstrValid, bus.Pc, bus.Busy, bus.Done);
    end
  endtask

  task automatic write_word(input logic [3:0] a, input logic [11:0] d);
    drive(1'b1, a, d, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 12'h000, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  vec_t tbl [25];

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(1'b0, 4'd0, 12'h000, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("reset_held", 12'hF00, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check("reset_idle", 12'hF00, 1'b0, 4'd0, 1'b0, 1'b0);

`ifndef SEQ_LOOP_EN
    //             wr  wa     wd       last  st    pa    sp    instr    v     pc     busy  done
    tbl[0]  = mk(1'b1, 4'd0, 12'h105, 4'd0, 1'b0, 1'b0, 1'b0, 12'hF00, 1'b0, 4'd0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 4'd1, 12'h203, 4'd0, 1'b0, 1'b0, 1'b0, 12'hF00, 1'b0, 4'd0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 4'd2, 12'h400, 4'd0, 1'b0, 1'b0, 1'b0, 12'hF00, 1'b0, 4'd0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 4'd0, 12'h000, 4'd2, 1'b1, 1'b0, 1'b0, 12'h105, 1'b1, 4'd1, 1'b1, 1'b0);
    tbl[4]  = mk(1'b0, 4'd0, 12'h000, 4'd0, 1'b0, 1'b0, 1'b0, 12'h203, 1'b1, 4'd2, 1'b1, 1'b0);
    tbl[5]  = mk(1'b0, 4'd0, 12'h000, 4'd0, 1'b0, 1'b0, 1'b0, 12'h400, 1'b1, 4'd3, 1'b1, 1'b0);
    tbl[6]  = mk(1'b0, 4'd0, 12'h000, 4'd0, 1'b0, 1'b0, 1'b0, 12'hF00, 1'b0, 4'd3, 1'b0, 1'b1);
    tbl[7]  = mk(1'b0, 4'd0, 12'h000, 4'd0, 1'b0, 1'b0, 1'b0, 12'hF00, 1'b0, 4'd3, 1'b0, 1'b1);
    tbl[8]  = mk(1'b1, 4'd1, 12'hE00, 4'd0, 1'b0, 1'b0, 1'b0, 12'hF00, 1'b0, 4'd3, 1'b0, 1'b1);
    tbl[9]  = mk(1'b0, 4'd0, 12'h000, 4'd2, 1'b1, 1'b0, 1'b0, 12'h105, 1'b1, 4'd1, 1'b1, 1'b0);
    tbl[10] = mk(1'b0, 4'd0, 12'h000, 4'd0, 1'b0, 1'b0, 1'b0, 12'hF00, 1'b0, 4'd1, 1'b0, 1'b1);
    tbl[11] = mk(1'b0, 4'd0, 12'h000, 4'd0, 1'b0, 1'b0, 1'b0, 12'hF00, 1'b0, 4'd1, 1'b0, 1'b1);
    tbl[12] = mk(1'b1, 4'd1, 12'h203, 4'd0, 1'b0, 1'b0, 1'b0, 12'hF00, 1'b0, 4'd1, 1'b0, 1'b1);
    tbl[13] = mk(1'b0, 4'd0, 12'h000, 4'd2, 1'b1, 1'b0, 1'b0, 12'h105, 1'b1, 4'd1, 1'b1, 1'b0);
    tbl[14] = mk(1'b0, 4'd0, 12'h000, 4'd0, 1'b0, 1'b1, 1'b0, 12'hF00, 1'b0, 4'd1, 1'b1, 1'b0);
    tbl[15] = mk(1'b0, 4'd0, 12'h000, 4'd0, 1'b0, 1'b1, 1'b0, 12'hF00, 1'b0, 4'd1, 1'b1, 1'b0);
    tbl[16] = mk(1'b0, 4'd0, 12'h000, 4'd0, 1'b0, 1'b1, 1'b0, 12'hF00, 1'b0, 4'd1, 1'b1, 1'b0);
    tbl[17] = mk(1'b0, 4'd0, 12'h000, 4'd0, 1'b0, 1'b0, 1'b0, 12'h203, 1'b1, 4'd2, 1'b1, 1'b0);
    tbl[18] = mk(1'b0, 4'd0, 12'h000, 4'd2, 1'b1, 1'b1, 1'b1, 12'hF00, 1'b0, 4'd0, 1'b0, 1'b0);
    tbl[19] = mk(1'b0, 4'd0, 12'h000, 4'd2, 1'b1, 1'b0, 1'b0, 12'h105, 1'b1, 4'd1, 1'b1, 1'b0);
    tbl[20] = mk(1'b1, 4'd1, 12'h777, 4'd0, 1'b0, 1'b0, 1'b0, 12'h203, 1'b1, 4'd2, 1'b1, 1'b0);
    tbl[21] = mk(1'b0, 4'd0, 12'h000, 4'd0, 1'b0, 1'b0, 1'b0, 12'h400, 1'b1, 4'd3, 1'b1, 1'b0);
    tbl[22] = mk(1'b0, 4'd0, 12'h000, 4'd0, 1'b0, 1'b0, 1'b0, 12'hF00, 1'b0, 4'd3, 1'b0, 1'b1);
    tbl[23] = mk(1'b0, 4'd0, 12'h000, 4'd2, 1'b1, 1'b0, 1'b0, 12'h105, 1'b1, 4'd1, 1'b1, 1'b0);
    tbl[24] = mk(1'b0, 4'd0, 12'h000, 4'd0, 1'b0, 1'b0, 1'b0, 12'h203, 1'b1, 4'd2, 1'b1, 1'b0);

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].last, tbl[i].st, tbl[i].pa, tbl[i].sp);
      tick();
      check($sformatf("vec%0d", i), tbl[i].ei, tbl[i].ev, tbl[i].ep, tbl[i].eb, tbl[i].ed);
    end

    // Stop back to IDLE, then write word 0 and Start on the same edge:
    // the first fetch must still see the old word.
    drive(1'b0, 4'd0, 12'h000, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    check("stop_idle", 12'hF00, 1'b0, 4'd0, 1'b0, 1'b0);
    drive(1'b1, 4'd0, 12'h111, 4'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check("wr_start_old", 12'h105, 1'b1, 4'd1, 1'b1, 1'b0);
    drive(1'b0, 4'd0, 12'h000, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("end0_done", 12'hF00, 1'b0, 4'd1, 1'b0, 1'b1);
    drive(1'b0, 4'd0, 12'h000, 4'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check("wr_start_new", 12'h111, 1'b1, 4'd1, 1'b1, 1'b0);
    drive(1'b0, 4'd0, 12'h000, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
`endif

    // HALT at address 0: straight to DONE with Pc=0.
    drive(1'b0, 4'd0, 12'h000, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    write_word(4'd0, 12'hE12);
    drive(1'b0, 4'd0, 12'h000, 4'd3, 1'b1, 1'b0, 1'b0);
    tick();
    check("halt_at_0", 12'hF00, 1'b0, 4'd0, 1'b0, 1'b1);

    // Reset in the middle of a run.
    write_word(4'd0, 12'h105);
    write_word(4'd1, 12'h203);
    write_word(4'd2, 12'h400);
    drive(1'b0, 4'd0, 12'h000, 4'd2, 1'b1, 1'b0, 1'b0);
    tick();
    check("pre_reset_run", 12'h105, 1'b1, 4'd1, 1'b1, 1'b0);
    drive(1'b0, 4'd0, 12'h000, 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check("reset_midrun", 12'hF00, 1'b0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

`ifdef SEQ_LOOP_EN
    // Loop over addresses 0..1 with no bubble, then Stop.
    drive(1'b0, 4'd0, 12'h000, 4'd1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 12'h000, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      if (i % 2 == 0) check($sformatf("loop%0d", i), 12'h105, 1'b1, 4'd1, 1'b1, 1'b0);
      else            check($sformatf("loop%0d", i), 12'h203, 1'b1, 4'd2, 1'b1, 1'b0);
    end
    drive(1'b0, 4'd0, 12'h000, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    check("loop_stop", 12'hF00, 1'b0, 4'd0, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 12'h000, 4'd0, 1'b0, 1'b0, 1'b0);
`else
    // Randomized runs. The model derives the list of issued addresses from
    // the program and End, then plays it out with random pause cycles.
    for (int run = 0; run < 20; run++) begin
      int          q[$];
      int          halt_at;
      int          last;
      int          final_pc;
      int          k;
      int          cyc;
      bit          finished;
      logic [11:0] w;

      for (int a = 0; a < 16; a++) begin
        if ($urandom_range(0, 6) == 0) w = {4'hE, 8'($urandom_range(0, 255))};
        else                           w = 12'($urandom_range(0, 4095));
        if (w[11:8] == 4'hE && run % 3 == 0) w[11:8] = 4'h3;
        write_word(4'(a), w);
      end
      last    = $urandom_range(0, 15);
      halt_at = -1;
      q.delete();
      for (int a = 0; a <= last; a++) begin
        if (model_mem[a][11:8] == 4'hE) begin
          halt_at = a;
          break;
        end
        q.push_back(a);
      end
      final_pc = (halt_at >= 0) ? halt_at : (last + 1) % 16;

      drive(1'b0, 4'd0, 12'h000, 4'(last), 1'b1, 1'b0, 1'b0);
      tick();
      if (q.size() == 0) begin
        check($sformatf("rnd%0d_start", run), 12'hF00, 1'b0, 4'(final_pc), 1'b0, 1'b1);
        finished = 1'b1;
      end else begin
        check($sformatf("rnd%0d_start", run), model_mem[q[0]], 1'b1, 4'((q[0] + 1) % 16), 1'b1, 1'b0);
        finished = 1'b0;
      end
      k   = 1;
      cyc = 0;
      while (!finished && cyc < 200) begin
        bit p;
        p = ($urandom_range(0, 3) == 0);
        drive(1'b0, 4'd0, 12'h000, 4'd0, 1'b0, p, 1'b0);
        tick();
        if (p) begin
          check($sformatf("rnd%0d_c%0d_pause", run, cyc), 12'hF00, 1'b0,
                4'((q[k-1] + 1) % 16), 1'b1, 1'b0);
        end else if (k < q.size()) begin
          check($sformatf("rnd%0d_c%0d", run, cyc), model_mem[q[k]], 1'b1,
                4'((q[k] + 1) % 16), 1'b1, 1'b0);
          k++;
        end else begin
          check($sformatf("rnd%0d_c%0d_done", run, cyc), 12'hF00, 1'b0,
                4'(final_pc), 1'b0, 1'b1);
          finished = 1'b1;
        end
        cyc++;
      end
      if (!finished) begin
        total++;
        bad++;
        $display("FAIL rnd%0d_bound: run did not finish within 200 cycles, want finished", run);
      end
      drive(1'b0, 4'd0, 12'h000, 4'd0, 1'b0, 1'b0, 1'b0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Upstream feeder for the tiny CPU. Holds a small program of 12-bit instruction words and steps through it with a program counter.
- Presents one word per clock on the CPU's 12-bit instruction input.
- Program is loaded through a write port while idle. Execution is started, paused, or stopped by control pulses.
- When nothing is being issued, the block drives a NOP word so the CPU's registers hold their values.

Parameters:
- DEPTH, 16, number of program words.
- AW, 4, address width (clog2 of DEPTH).
- NOP_OPCODE, 4'hF, opcode whose decode enables no CPU register.
- HALT_OPCODE, 4'hE, opcode that ends the run; it is never issued to the CPU.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- WrEn  input  1  program write strobe; honoured only in IDLE or DONE.
- WrAddr  input  AW  program write address.
- WrData  input  12  program word: [11:8] opcode, [7:0] data.
- LastAddr  input  AW  final address of the program; sampled on Start.
- Start  input  1  one-cycle pulse: begin a run at address 0.
- Pause  input  1  level: while high, no Pc advance and NOP is issued.
- Stop  input  1  one-cycle pulse: abort the run and return to IDLE.
- Instr  output  12  word to the CPU; bits [11:8] opcode, [7:0] data.
- InstrValid  output  1  high when Instr is a real program word.
- Pc  output  AW  address of the next word to fetch.
- Busy  output  1  high in RUN.
- Done  output  1  high in DONE.

Behaviour:
- Reset values: state IDLE, Pc=0, Instr={NOP_OPCODE,8'h00}, InstrValid=0, Busy=0, Done=0.
- Program memory contents are not reset.
- All outputs are registered.
- Memory write is synchronous. WrEn is ignored in RUN. A write and a Start on the same edge: the write happens and the run starts, but the first fetch returns the old word.
- States: IDLE, RUN, DONE.
- IDLE/DONE with Start=1:
  - Latch LastAddr internally as End.
  - If mem[0] is a HALT word, go to DONE with Pc=0 and Instr=NOP.
  - Otherwise issue Instr=mem[0], InstrValid=1, Pc=1, state RUN.
  - Latency: the first word is visible on the cycle after the Start edge.
- RUN, each edge with Pause=0, Stop=0:
  - Instr=mem[Pc], InstrValid=1, Pc=Pc+1.
  - If the word issued on the previous edge came from address End, issue NOP instead, set InstrValid=0, and go to DONE. Pc stays at End+1, wrapping mod DEPTH.
  - If mem[Pc] has opcode HALT_OPCODE, issue NOP, set InstrValid=0, hold Pc at the HALT address, and go to DONE.
- RUN with Pause=1: Instr=NOP, InstrValid=0, Pc held. Resuming continues at the held Pc with no skipped or duplicated word.
- Stop in any state: next edge gives IDLE, Pc=0, Instr=NOP, InstrValid=0. Stop wins over Start and Pause on the same edge.
- Start while in RUN is ignored.
- Pc arithmetic is modulo DEPTH. End=DEPTH-1 issues the full memory.
- Reset mid-run: same as the reset values above; the partially run program is abandoned.
- Exactly one of Busy and Done is high, except in IDLE where both are low.

Optional Feature:
- Macro SEQ_LOOP_EN.
- Defined: in RUN, after issuing the word at End, the next edge issues mem[0] with Pc=1 and the state stays RUN, giving a continuous loop with no NOP bubble. HALT_OPCODE still terminates to DONE. Stop and Pause behave as above.
- Undefined: termination at End as described in Behaviour.

Decomposition:
- Shared package holds:
  - the opcode field slice constants (OPC_MSB=11, OPC_LSB=8, DATA_MSB=7);
  - NOP and HALT opcode localparams;
  - the state enum IDLE/RUN/DONE;
  - a function building the NOP word.
- One sub-module, prog_mem: DEPTH×12 register array with a synchronous write port and an asynchronous read port. The sequencer registers the read data into Instr.

Test Plan:
- Load 0:{4'h1,8'h05}, 1:{4'h2,8'h03}, 2:{4'h4,8'h00}; LastAddr=2; Start -> Instr=105,203,400 on three consecutive cycles with InstrValid=1, then F00 with InstrValid=0 and Done=1; Pc reads 1,2,3.
- Same program with word 1 replaced by HALT E00 -> 105 issued, then NOP, Done=1, Pc=1; E00 never appears on Instr.
- Pause high for 3 cycles after the first word -> three F00 cycles with Pc held at 1, then 203 and 400 in order.
- Stop asserted while Pc=2, together with Start -> IDLE, Pc=0, Instr=F00; a later Start restarts at word 0.
- WrEn to address 1 during RUN -> memory unchanged: a rerun still issues the old word at 1. Reset mid-run -> all outputs return to reset values on the next cycle.
- With SEQ_LOOP_EN and LastAddr=1 -> 105,203,105,203... with no bubble until Stop.
